// File: rtl/stim_pair_sequencer_pkg.sv
// Shared types and defaults for the ordered-pair stimulus sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package stim_pair_sequencer_pkg;

  localparam int IN_SIZE_DEF    = 4;
  localparam int SIM_DEF        = 16;
  localparam int HOLD_DEF       = 1;
  localparam int CLK_PERIOD_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY_I,
    ST_APPLY_J,
    ST_WAIT_ACK,
    ST_DONE
  } state_t;

  // Index width for SIM*SIM pairs; a single pair still needs one bit.
  function automatic int idx_width(input int sim);
    return (sim * sim > 1) ? $clog2(sim * sim) : 1;
  endfunction

endpackage

// File: rtl/stim_pair_sequencer_hold_timer.sv
// Loadable down-counter marking the first and last cycle of a HOLD-cycle window.
// Latency: flags are decoded from the count register; load takes effect next cycle.
// Backpressure: none; counts only while run is high and stops at zero.
module hold_timer #(
  parameter int HOLD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic first,
  output logic last
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] TOP = CW'(HOLD - 1);

  logic [CW-1:0] cnt;

  // Reload at the start of each window, then count down to zero and park there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TOP;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign first = (cnt == TOP);
  assign last  = (cnt == '0);

endmodule

// File: rtl/stim_pair_sequencer.sv
// Walks every ordered pair (i, j) applying i then j, with begin/end strobes and pair index.
// Latency: start seen at edge t gives the first APPLY_I cycle right after it; pair = 2*HOLD+1 cycles with ack high.
// Backpressure: waits in WAIT_ACK holding j until ack; start while busy is ignored.
module stim_pair_sequencer
  import stim_pair_sequencer_pkg::*;
#(
  parameter int IN_SIZE = IN_SIZE_DEF,
  parameter int SIM     = SIM_DEF,
  parameter int HOLD    = HOLD_DEF,
  parameter int IDX_W   = idx_width(SIM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ack,
  output logic [IN_SIZE-1:0] in_o,
  output logic [IDX_W-1:0]   sim_idx,
  output logic               begin_p,
  output logic               end_p,
  output logic               busy,
  output logic               done
);

  localparam logic [IN_SIZE-1:0] LAST_VAL = IN_SIZE'(SIM - 1);

  state_t             state, state_nx;
  logic [IN_SIZE-1:0] i_q, i_nx, j_q, j_nx;
  logic [IDX_W-1:0]   idx_q, idx_nx;
  logic               t_load, t_run, t_first, t_last;

  hold_timer #(.HOLD(HOLD)) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (t_load),
    .run   (t_run),
    .first (t_first),
    .last  (t_last)
  );

  assign t_run = (state == ST_APPLY_I) || (state == ST_APPLY_J);

  // Next-state and operand stepping; the timer is reloaded on entry to each apply phase.
  always_comb begin
    state_nx = state;
    i_nx     = i_q;
    j_nx     = j_q;
    idx_nx   = idx_q;
    t_load   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx = ST_APPLY_I;
          i_nx     = '0;
          j_nx     = '0;
          idx_nx   = '0;
          t_load   = 1'b1;
        end
      end
      ST_APPLY_I: begin
        if (t_last) begin
          state_nx = ST_APPLY_J;
          t_load   = 1'b1;
        end
      end
      ST_APPLY_J: begin
        if (t_last) begin
          state_nx = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack) begin
          if (j_q != LAST_VAL) begin
            j_nx     = j_q + 1'b1;
            idx_nx   = idx_q + 1'b1;
            state_nx = ST_APPLY_I;
            t_load   = 1'b1;
          end else if (i_q != LAST_VAL) begin
            j_nx     = '0;
            i_nx     = i_q + 1'b1;
            idx_nx   = idx_q + 1'b1;
            state_nx = ST_APPLY_I;
            t_load   = 1'b1;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State and operand registers; reset abandons any sweep in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      i_q   <= '0;
      j_q   <= '0;
      idx_q <= '0;
    end else begin
      state <= state_nx;
      i_q   <= i_nx;
      j_q   <= j_nx;
      idx_q <= idx_nx;
    end
  end

  // Outputs decode registers only, so start/ack never reach them combinationally.
  assign in_o    = (state == ST_APPLY_I) ? i_q : j_q;
  assign sim_idx = idx_q;
  assign begin_p = (state == ST_APPLY_I) && t_first;
  assign end_p   = (state == ST_APPLY_J) && t_last;
  assign busy    = (state == ST_APPLY_I) || (state == ST_APPLY_J) || (state == ST_WAIT_ACK);
  assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_stim_pair_sequencer.sv
// Directed bench for the pair sequencer across four parameter sets.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: ack withheld on the SIM=3 instance to stall a pair.
module tb_stim_pair_sequencer;
  import stim_pair_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // SIM=2 HOLD=1
  logic       start_a = 1'b0, ack_a = 1'b1;
  logic [3:0] in_a;
  logic [1:0] idx_a;
  logic       beg_a, end_a, busy_a, done_a;
  // SIM=3 HOLD=2
  logic       start_b = 1'b0, ack_b = 1'b1;
  logic [3:0] in_b;
  logic [3:0] idx_b;
  logic       beg_b, end_b, busy_b, done_b;
  // SIM=1 HOLD=3
  logic       start_c = 1'b0, ack_c = 1'b1;
  logic [3:0] in_c;
  logic [0:0] idx_c;
  logic       beg_c, end_c, busy_c, done_c;
  // SIM=16 HOLD=1
  logic       start_d = 1'b0, ack_d = 1'b1;
  logic [3:0] in_d;
  logic [7:0] idx_d;
  logic       beg_d, end_d, busy_d, done_d;

  always #(CLK_PERIOD_DEF / 2) clk = ~clk;

  stim_pair_sequencer #(.IN_SIZE(4), .SIM(2), .HOLD(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .ack(ack_a), .in_o(in_a), .sim_idx(idx_a),
    .begin_p(beg_a), .end_p(end_a), .busy(busy_a), .done(done_a));
  stim_pair_sequencer #(.IN_SIZE(4), .SIM(3), .HOLD(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .ack(ack_b), .in_o(in_b), .sim_idx(idx_b),
    .begin_p(beg_b), .end_p(end_b), .busy(busy_b), .done(done_b));
  stim_pair_sequencer #(.IN_SIZE(4), .SIM(1), .HOLD(3)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .ack(ack_c), .in_o(in_c), .sim_idx(idx_c),
    .begin_p(beg_c), .end_p(end_c), .busy(busy_c), .done(done_c));
  stim_pair_sequencer #(.IN_SIZE(4), .SIM(16), .HOLD(1)) u_d (
    .clk(clk), .rst(rst), .start(start_d), .ack(ack_d), .in_o(in_d), .sim_idx(idx_d),
    .begin_p(beg_d), .end_p(end_d), .busy(busy_d), .done(done_d));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (in_a !== 4'd0) begin errors++; $display("FAIL reset_in_a: got %0d expected 0", in_a); end
    checks++; if (idx_a !== 2'd0) begin errors++; $display("FAIL reset_idx_a: got %0d expected 0", idx_a); end
    checks++; if (beg_a !== 1'b0 || end_a !== 1'b0) begin errors++; $display("FAIL reset_strobes_a: got %b%b expected 00", beg_a, end_a); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL reset_status_a: got %b%b expected 00", busy_a, done_a); end
    checks++; if (busy_d !== 1'b0 || done_d !== 1'b0 || idx_d !== 8'd0) begin errors++; $display("FAIL reset_d: got busy=%b done=%b idx=%0d expected 0 0 0", busy_d, done_d, idx_d); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_sim2_sweep();
    logic [3:0] exp_in [12];
    exp_in = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int k = 0; k < 12; k++) begin
      checks++; if (in_a !== exp_in[k]) begin errors++; $display("FAIL sim2_in cycle %0d: got %0d expected %0d", k + 1, in_a, exp_in[k]); end
      checks++; if (beg_a !== (k % 3 == 0)) begin errors++; $display("FAIL sim2_begin cycle %0d: got %b expected %b", k + 1, beg_a, (k % 3 == 0)); end
      checks++; if (end_a !== (k % 3 == 1)) begin errors++; $display("FAIL sim2_end cycle %0d: got %b expected %b", k + 1, end_a, (k % 3 == 1)); end
      checks++; if (idx_a !== 2'(k / 3)) begin errors++; $display("FAIL sim2_idx cycle %0d: got %0d expected %0d", k + 1, idx_a, k / 3); end
      checks++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin errors++; $display("FAIL sim2_busy cycle %0d: got busy=%b done=%b expected 1 0", k + 1, busy_a, done_a); end
      step();
    end
    checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL sim2_done: got done=%b busy=%b expected 1 0", done_a, busy_a); end
    checks++; if (idx_a !== 2'd3 || in_a !== 4'd1) begin errors++; $display("FAIL sim2_final: got idx=%0d in=%0d expected 3 1", idx_a, in_a); end
  endtask

  task automatic test_reset_mid_sweep();
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int k = 0; k < 5; k++) step();
    checks++; if (in_a !== 4'd1 || busy_a !== 1'b1) begin errors++; $display("FAIL mid_pre_reset: got in=%0d busy=%b expected 1 1", in_a, busy_a); end
    rst = 1'b1; #1;
    checks++; if (in_a !== 4'd0 || idx_a !== 2'd0) begin errors++; $display("FAIL mid_reset_data: got in=%0d idx=%0d expected 0 0", in_a, idx_a); end
    checks++; if ({beg_a, end_a, busy_a, done_a} !== 4'b0000) begin errors++; $display("FAIL mid_reset_flags: got %b expected 0000", {beg_a, end_a, busy_a, done_a}); end
    start_a = 1'b1; step();
    checks++; if (busy_a !== 1'b0 || beg_a !== 1'b0) begin errors++; $display("FAIL start_with_rst: got busy=%b begin=%b expected 0 0", busy_a, beg_a); end
    rst = 1'b0; start_a = 1'b0; step();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL no_resume: got busy=%b expected 0", busy_a); end
    start_a = 1'b1; step(); start_a = 1'b0;
    checks++; if (beg_a !== 1'b1 || in_a !== 4'd0 || idx_a !== 2'd0) begin errors++; $display("FAIL restart_pair0: got begin=%b in=%0d idx=%0d expected 1 0 0", beg_a, in_a, idx_a); end
    step(); step(); step();
    checks++; if (beg_a !== 1'b1 || idx_a !== 2'd1 || in_a !== 4'd0) begin errors++; $display("FAIL restart_pair1: got begin=%b idx=%0d in=%0d expected 1 1 0", beg_a, idx_a, in_a); end
  endtask

  task automatic test_sim3_backpressure();
    ack_b = 1'b1;
    start_b = 1'b1; step(); start_b = 1'b0;
    for (int p = 0; p < 9; p++) begin
      checks++; if (beg_b !== 1'b1 || in_b !== 4'(p / 3) || idx_b !== 4'(p)) begin errors++; $display("FAIL sim3_begin pair %0d: got begin=%b in=%0d idx=%0d expected 1 %0d %0d", p, beg_b, in_b, idx_b, p / 3, p); end
      if (p == 6) start_b = 1'b1;
      step(); start_b = 1'b0;
      checks++; if (beg_b !== 1'b0 || in_b !== 4'(p / 3) || end_b !== 1'b0) begin errors++; $display("FAIL sim3_i2 pair %0d: got begin=%b in=%0d end=%b expected 0 %0d 0", p, beg_b, in_b, end_b, p / 3); end
      step();
      checks++; if (in_b !== 4'(p % 3) || end_b !== 1'b0) begin errors++; $display("FAIL sim3_j1 pair %0d: got in=%0d end=%b expected %0d 0", p, in_b, end_b, p % 3); end
      step();
      checks++; if (in_b !== 4'(p % 3) || end_b !== 1'b1) begin errors++; $display("FAIL sim3_j2 pair %0d: got in=%0d end=%b expected %0d 1", p, in_b, end_b, p % 3); end
      step();
      checks++; if (in_b !== 4'(p % 3) || busy_b !== 1'b1 || end_b !== 1'b0 || beg_b !== 1'b0) begin errors++; $display("FAIL sim3_wait pair %0d: got in=%0d busy=%b end=%b begin=%b expected %0d 1 0 0", p, in_b, busy_b, end_b, beg_b, p % 3); end
      if (p == 4) begin
        ack_b = 1'b0;
        for (int w = 0; w < 5; w++) begin
          step();
          checks++; if (in_b !== 4'd1 || idx_b !== 4'd4 || busy_b !== 1'b1 || beg_b !== 1'b0) begin errors++; $display("FAIL sim3_stall %0d: got in=%0d idx=%0d busy=%b begin=%b expected 1 4 1 0", w, in_b, idx_b, busy_b, beg_b); end
        end
        ack_b = 1'b1;
      end
      step();
    end
    checks++; if (done_b !== 1'b1 || busy_b !== 1'b0 || idx_b !== 4'd8 || in_b !== 4'd2) begin errors++; $display("FAIL sim3_done: got done=%b busy=%b idx=%0d in=%0d expected 1 0 8 2", done_b, busy_b, idx_b, in_b); end
  endtask

  task automatic test_sim1();
    int nb = 0;
    int ne = 0;
    ack_c = 1'b1;
    start_c = 1'b1; step(); start_c = 1'b0;
    checks++; if (beg_c !== 1'b1) begin errors++; $display("FAIL sim1_first_begin: got %b expected 1", beg_c); end
    for (int c = 0; c < 6; c++) begin
      checks++; if (in_c !== 4'd0 || busy_c !== 1'b1) begin errors++; $display("FAIL sim1_apply cycle %0d: got in=%0d busy=%b expected 0 1", c + 1, in_c, busy_c); end
      nb += int'(beg_c);
      ne += int'(end_c);
      if (c == 5) begin
        checks++; if (end_c !== 1'b1) begin errors++; $display("FAIL sim1_end_last: got %b expected 1", end_c); end
      end
      step();
    end
    checks++; if (nb != 1 || ne != 1) begin errors++; $display("FAIL sim1_strobe_count: got begin=%0d end=%0d expected 1 1", nb, ne); end
    checks++; if (busy_c !== 1'b1 || done_c !== 1'b0) begin errors++; $display("FAIL sim1_wait: got busy=%b done=%b expected 1 0", busy_c, done_c); end
    step();
    checks++; if (done_c !== 1'b1 || busy_c !== 1'b0 || idx_c !== 1'b0 || in_c !== 4'd0) begin errors++; $display("FAIL sim1_done: got done=%b busy=%b idx=%0d in=%0d expected 1 0 0 0", done_c, busy_c, idx_c, in_c); end
  endtask

  task automatic test_full_sweep();
    int cyc = 1;
    int nb = 0;
    bit wrapped = 1'b0;
    logic [7:0] prev = '0;
    ack_d = 1'b1;
    start_d = 1'b1; step(); start_d = 1'b0;
    while (done_d !== 1'b1 && cyc < 2000) begin
      if (beg_d === 1'b1) nb++;
      if (idx_d < prev) wrapped = 1'b1;
      prev = idx_d;
      step();
      cyc++;
    end
    checks++; if (done_d !== 1'b1) begin errors++; $display("FAIL full_timeout: got done=%b expected 1 within 2000 cycles", done_d); end
    checks++; if (cyc != 769) begin errors++; $display("FAIL full_length: got done at cycle %0d expected 769", cyc); end
    checks++; if (nb != 256) begin errors++; $display("FAIL full_begin_count: got %0d expected 256", nb); end
    checks++; if (idx_d !== 8'd255 || in_d !== 4'd15) begin errors++; $display("FAIL full_final: got idx=%0d in=%0d expected 255 15", idx_d, in_d); end
    checks++; if (wrapped) begin errors++; $display("FAIL full_wrap: got wrap=1 expected 0"); end
  endtask

  initial begin
    test_reset();
    test_sim2_sweep();
    test_reset_mid_sweep();
    test_sim3_backpressure();
    test_sim1();
    test_full_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
